// File: rtl/daq_mode_arbiter.sv
// Run-control arbiter: hands the Microroc slow-control path and the USB data
// path to one of NUM_MODES acquisition sources and sequences start/abort/drain.
module daq_mode_arbiter #(
  parameter  int NUM_MODES = 4,
  parameter  int DAC_W     = 10,
  parameter  int NUM_DAC   = 3,
  parameter  int CHN_W     = 7,
  parameter  int DATA_W    = 16,
  parameter  int TMO_W     = 24,
  localparam int MODE_W    = $clog2(NUM_MODES)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [MODE_W-1:0]                 mode_sel_i,
  input  logic                              run_start_i,
  input  logic                              run_stop_i,
  output logic [NUM_MODES-1:0]              src_start_o,
  input  logic [NUM_MODES-1:0]              src_done_i,
  input  logic [NUM_MODES*NUM_DAC*DAC_W-1:0] src_dac_i,
  input  logic [NUM_MODES*CHN_W-1:0]        src_ctest_i,
  input  logic [NUM_MODES-1:0]              src_sc_load_i,
  input  logic [NUM_MODES*DATA_W-1:0]       src_data_i,
  input  logic [NUM_MODES-1:0]              src_data_en_i,
  input  logic                              config_done_i,
  output logic [NUM_DAC*DAC_W-1:0]          out_dac_o,
  output logic [CHN_W-1:0]                  out_ctest_o,
  output logic                              out_sc_load_o,
  output logic [NUM_MODES-1:0]              src_config_done_o,
  input  logic                              usb_fifo_full_i,
  output logic [DATA_W-1:0]                 usb_data_o,
  output logic                              usb_data_en_o,
  input  logic                              data_transmit_done_i,
  output logic                              busy_o,
  output logic [MODE_W-1:0]                 active_mode_o,
  output logic                              run_done_o,
  output logic [2:0]                        err_flags_o,
  output logic [15:0]                       drop_count_o
);

  localparam int DACS_W = NUM_DAC * DAC_W;
  localparam logic [MODE_W:0] NM_L = (MODE_W+1)'(NUM_MODES);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_ABORT, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [MODE_W-1:0]      mode_q, mode_d;
  logic [TMO_W-1:0]       wdog_q, wdog_d;
  logic                   done_prev_q;
  logic [2:0]             err_q, err_d;
  logic [15:0]            drop_q, drop_d;
  logic [NUM_MODES-1:0]   start_q, start_d;
  logic [DACS_W-1:0]      dac_q, dac_d;
  logic [CHN_W-1:0]       ctest_q, ctest_d;
  logic                   scl_q, scl_d;
  logic [NUM_MODES-1:0]   cfg_q, cfg_d;
  logic [DATA_W-1:0]      udata_q, sdata;
  logic                   uen_q, uen_d;
  logic                   busy_q, run_done_q;

  logic [MODE_W-1:0]      sel;
  logic                   sen, sdone, data_st, drop_hit, expire, done_rise, start_en;

  // Source mux: owner while busy, the normal ACQ path (mode 0) while idle.
  always_comb begin
    sel     = (state_q == S_IDLE) ? '0 : mode_q;
    dac_d   = '0;
    ctest_d = '0;
    scl_d   = 1'b0;
    cfg_d   = '0;
    sdata   = '0;
    sen     = 1'b0;
    sdone   = 1'b0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (sel == MODE_W'(m)) begin
        dac_d    = src_dac_i[m*DACS_W +: DACS_W];
        ctest_d  = src_ctest_i[m*CHN_W +: CHN_W];
        scl_d    = src_sc_load_i[m];
        cfg_d[m] = config_done_i;
        sdata    = src_data_i[m*DATA_W +: DATA_W];
        sen      = src_data_en_i[m];
        sdone    = src_done_i[m];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    err_d     = err_q;
    drop_d    = drop_q;
    data_st   = (state_q == S_RUN) || (state_q == S_ABORT) || (state_q == S_DRAIN);
    uen_d     = data_st & sen & ~usb_fifo_full_i;
    drop_hit  = data_st & sen & usb_fifo_full_i;
    expire    = &wdog_q;
    done_rise = sdone & ~done_prev_q;

    case (state_q)
      S_IDLE: begin
        if (run_start_i) begin
          if ({1'b0, mode_sel_i} < NM_L) begin
            mode_d  = mode_sel_i;
            err_d   = '0;
            drop_d  = '0;
            state_d = S_ARM;
          end else begin
            err_d[1] = 1'b1;
          end
        end
      end
      S_ARM: state_d = S_RUN;
      S_RUN: begin
        if (sdone) begin
          state_d = S_DRAIN;
        end else if (run_stop_i) begin
          state_d = S_ABORT;
        end else if (expire) begin
          state_d  = S_ABORT;
          err_d[2] = 1'b1;
        end
      end
      S_ABORT: begin
        if (done_rise) begin
          state_d = S_DRAIN;
        end else if (expire) begin
          state_d  = S_DRAIN;
          err_d[2] = 1'b1;
        end
      end
      S_DRAIN: if (data_transmit_done_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (drop_hit) begin
      err_d[0] = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    if (((state_d != state_q) && ((state_d == S_RUN) || (state_d == S_ABORT))) || uen_d)
      wdog_d = '0;
    else if (!expire)
      wdog_d = wdog_q + TMO_W'(1);
    else
      wdog_d = wdog_q;

    // Start is dropped on the same edge the FSM leaves RUN.
    start_en = (state_q == S_ARM) || ((state_q == S_RUN) && (state_d == S_RUN));
    start_d  = '0;
    for (int m = 0; m < NUM_MODES; m++)
      start_d[m] = start_en && (mode_q == MODE_W'(m));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      wdog_q      <= '0;
      done_prev_q <= 1'b0;
      err_q       <= '0;
      drop_q      <= '0;
      start_q     <= '0;
      dac_q       <= '0;
      ctest_q     <= '0;
      scl_q       <= 1'b0;
      cfg_q       <= '0;
      udata_q     <= '0;
      uen_q       <= 1'b0;
      busy_q      <= 1'b0;
      run_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wdog_q      <= wdog_d;
      done_prev_q <= sdone;
      err_q       <= err_d;
      drop_q      <= drop_d;
      start_q     <= start_d;
      dac_q       <= dac_d;
      ctest_q     <= ctest_d;
      scl_q       <= scl_d;
      cfg_q       <= cfg_d;
      udata_q     <= sdata;
      uen_q       <= uen_d;
      busy_q      <= (state_d != S_IDLE);
      run_done_q  <= (state_d == S_DONE);
    end
  end

  assign src_start_o       = start_q;
  assign out_dac_o         = dac_q;
  assign out_ctest_o       = ctest_q;
  assign out_sc_load_o     = scl_q;
  assign src_config_done_o = cfg_q;
  assign usb_data_o        = udata_q;
  assign usb_data_en_o     = uen_q;
  assign busy_o            = busy_q;
  assign active_mode_o     = mode_q;
  assign run_done_o        = run_done_q;
  assign err_flags_o       = err_q;
  assign drop_count_o      = drop_q;

endmodule

// File: tb/tb_daq_mode_arbiter.sv
// Bench for daq_mode_arbiter: three sources with a 4-bit watchdog; USB words
// are scoreboarded, control outputs checked at fixed cycle points.
module tb_daq_mode_arbiter;
  localparam int NM = 3;
  localparam int MW = $clog2(NM);
  localparam int DW = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [MW-1:0]      mode_sel;
  logic               run_start, run_stop;
  logic [NM-1:0]      src_start, src_done, src_sc_load, src_data_en, src_config_done;
  logic [NM*30-1:0]   src_dac;
  logic [NM*7-1:0]    src_ctest;
  logic [NM*DW-1:0]   src_data;
  logic               config_done, usb_fifo_full, data_transmit_done;
  logic [29:0]        out_dac;
  logic [6:0]         out_ctest;
  logic               out_sc_load, usb_data_en, busy, run_done;
  logic [DW-1:0]      usb_data;
  logic [MW-1:0]      active_mode;
  logic [2:0]         err_flags;
  logic [15:0]        drop_count;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [DW-1:0] sb_q[$];

  daq_mode_arbiter #(.NUM_MODES(NM), .TMO_W(4)) dut (
    .clk_i(clk), .reset_i(reset), .mode_sel_i(mode_sel), .run_start_i(run_start),
    .run_stop_i(run_stop), .src_start_o(src_start), .src_done_i(src_done),
    .src_dac_i(src_dac), .src_ctest_i(src_ctest), .src_sc_load_i(src_sc_load),
    .src_data_i(src_data), .src_data_en_i(src_data_en), .config_done_i(config_done),
    .out_dac_o(out_dac), .out_ctest_o(out_ctest), .out_sc_load_o(out_sc_load),
    .src_config_done_o(src_config_done), .usb_fifo_full_i(usb_fifo_full),
    .usb_data_o(usb_data), .usb_data_en_o(usb_data_en),
    .data_transmit_done_i(data_transmit_done), .busy_o(busy),
    .active_mode_o(active_mode), .run_done_o(run_done), .err_flags_o(err_flags),
    .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every USB write must match the next expected word.
  always @(negedge clk) begin
    if (usb_data_en) begin
      wr_cnt++;
      if (sb_q.size() == 0) chk("sb_unexpected_write", usb_data, 64'hFFFF_FFFF);
      else                  chk("usb_data", usb_data, sb_q.pop_front());
    end
  end

  task automatic start_run(input logic [MW-1:0] m);
    mode_sel  = m;
    run_start = 1'b1;
    tick();                       // ARM
    run_start = 1'b0;
    tick();                       // RUN
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mode_sel = '0; run_start = 0; run_stop = 0; src_done = '0;
    src_sc_load = 3'b010; src_data_en = '0; src_data = '0; config_done = 1'b1;
    usb_fifo_full = 0; data_transmit_done = 0;
    for (int m = 0; m < NM; m++) begin
      src_dac[m*30 +: 30] = 30'(100 + m);
      src_ctest[m*7 +: 7] = 7'(10 + m);
    end
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_start", src_start, 0);
    chk("rst_dac", out_dac, 0);
    chk("rst_cfg", src_config_done, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b0;
    tick();
    chk("idle_dac_mode0", out_dac, 100);
    chk("idle_ctest_mode0", out_ctest, 10);
    chk("idle_cfg_mode0", src_config_done, 3'b001);
    chk("idle_scl_mode0", out_sc_load, 0);

    // Mode 2 start, then abort via run_stop.
    mode_sel = 2; run_start = 1'b1;
    tick();
    run_start = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_active", active_mode, 2);
    chk("arm_start", src_start, 0);
    tick();
    chk("run_start2", src_start, 3'b100);
    chk("run_dac2", out_dac, 102);
    run_stop = 1'b1;
    tick();
    run_stop = 1'b0;
    chk("abort_start", src_start, 0);
    chk("abort_busy", busy, 1);
    src_done = 3'b100;
    tick();                       // DRAIN
    src_done = '0; data_transmit_done = 1'b1;
    tick();
    data_transmit_done = 1'b0;
    chk("abort_run_done", run_done, 1);
    tick();
    chk("abort_run_done_low", run_done, 0);
    chk("abort_idle", busy, 0);
    chk("abort_active_hold", active_mode, 2);
    tick();
    chk("idle_back_mode0", out_dac, 100);

    // Mode 1 data with back-pressure on words 4 and 5; mode 0 strobes are noise.
    start_run(1);
    chk("run1_cfg", src_config_done, 3'b010);
    chk("run1_scl", out_sc_load, 1);
    for (int w = 0; w < 10; w++) begin
      src_data[DW +: DW] = 16'hA000 + 16'(w);
      src_data[0 +: DW]  = 16'hDEAD;
      src_data_en        = 3'b010 | ((w % 3 == 0) ? 3'b001 : 3'b000);
      usb_fifo_full      = (w == 3) || (w == 4);
      if (!usb_fifo_full) sb_q.push_back(16'hA000 + 16'(w));
      tick();
    end
    src_data_en = '0; usb_fifo_full = 0;
    tick(); tick();
    chk("data_writes", wr_cnt, 8);
    chk("data_drop", drop_count, 2);
    chk("data_err", err_flags, 3'b001);
    src_done = 3'b010;
    tick();                       // DRAIN
    chk("drain_start", src_start, 0);
    src_data[DW +: DW] = 16'hB00B; src_data_en = 3'b010;
    sb_q.push_back(16'hB00B);
    tick();
    src_data_en = '0;
    tick(); tick(); tick();
    data_transmit_done = 1'b1;
    tick();
    data_transmit_done = 1'b0;
    chk("drain_run_done", run_done, 1);
    chk("done_busy", busy, 1);
    tick();
    chk("done_pulse_end", run_done, 0);
    chk("done_idle", busy, 0);
    chk("drain_writes", wr_cnt, 9);
    chk("drop_sticky", drop_count, 2);
    src_done = '0;

    // Out-of-range mode.
    mode_sel = 3; run_start = 1'b1;
    tick();
    run_start = 1'b0;
    chk("bad_mode_err", err_flags, 3'b011);
    chk("bad_mode_busy", busy, 0);
    chk("bad_mode_start", src_start, 0);

    // Watchdog timeout in mode 0 with mode_sel toggling.
    start_run(0);
    chk("new_run_err_clr", err_flags, 0);
    chk("new_run_drop_clr", drop_count, 0);
    for (int i = 0; i < 15; i++) begin
      mode_sel = MW'(i % 3);
      tick();
    end
    chk("pre_tmo_err", err_flags, 0);
    chk("pre_tmo_start", src_start, 3'b001);
    chk("toggle_active", active_mode, 0);
    tick();
    chk("tmo_err", err_flags, 3'b100);
    chk("tmo_start", src_start, 0);
    src_done = 3'b001;
    tick();                       // DRAIN
    data_transmit_done = 1'b1;
    tick();
    data_transmit_done = 1'b0; src_done = '0;
    chk("tmo_run_done", run_done, 1);
    tick();

    // run_stop and done together: done wins, so DRAIN accepts the drain pulse.
    start_run(0);
    run_stop = 1'b1; src_done = 3'b001;
    tick();
    run_stop = 1'b0; src_done = '0;
    chk("both_start", src_start, 0);
    data_transmit_done = 1'b1;
    tick();
    data_transmit_done = 1'b0;
    chk("both_run_done", run_done, 1);
    tick();

    // Reset in the middle of a run.
    start_run(2);
    chk("pre_rst_start", src_start, 3'b100);
    reset = 1'b1;
    tick();
    chk("mid_rst_start", src_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_active", active_mode, 0);
    chk("mid_rst_dac", out_dac, 0);
    chk("mid_rst_cfg", src_config_done, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_dac", out_dac, 100);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/daq_mode_arbiter.md
Name: daq_mode_arbiter

Overview:
- Parametrised successor to the DAQ top-level mode switcher.
- Arbitrates NUM_MODES acquisition sub-controllers (normal ACQ, SweepACQ, SCurve, spare) for ownership of the Microroc slow-control path and the USB data FIFO path.
- Owns a run-control FSM that latches the selected mode, starts the owner, and gates its data into the USB FIFO with full back-pressure accounting.
- Runs the watchdog and sequences the end-of-run done/drain handshake.

Parameters:
NUM_MODES, 4, number of source sub-controllers; MODE_W = clog2(NUM_MODES)
DAC_W, 10, width of one Microroc threshold DAC
NUM_DAC, 3, DACs per source
CHN_W, 7, CTest channel field width
DATA_W, 16, USB data word width
TMO_W, 24, watchdog counter width; timeout = 2^TMO_W-1 cycles

Ports:
Clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode_sel  in  MODE_W  requested mode
run_start  in  1  start pulse (USB command)
run_stop  in  1  abort pulse
src_start  out  NUM_MODES  one-hot level start to owning source
src_done  in  NUM_MODES  per-source done level
src_dac  in  NUM_MODES*NUM_DAC*DAC_W  per-source DAC codes, mode 0 in LSBs
src_ctest  in  NUM_MODES*CHN_W  per-source CTest channel
src_sc_load  in  NUM_MODES  per-source SC load pulse
src_data  in  NUM_MODES*DATA_W  per-source data
src_data_en  in  NUM_MODES  per-source data strobe
config_done  in  1  Microroc SC configuration complete
out_dac  out  NUM_DAC*DAC_W  muxed DAC codes
out_ctest  out  CHN_W  muxed CTest channel
out_sc_load  out  1  muxed SC load pulse
src_config_done  out  NUM_MODES  config_done routed to owner only
usb_fifo_full  in  1  USB FIFO full
usb_data  out  DATA_W  FIFO write data
usb_data_en  out  1  FIFO write enable
data_transmit_done  in  1  USB drain complete
busy  out  1  FSM not in IDLE
active_mode  out  MODE_W  latched owner
run_done  out  1  one-cycle end-of-run pulse
err_flags  out  3  {timeout, bad_mode, overflow}, sticky
drop_count  out  16  saturating count of dropped words

Behaviour:
- Reset: FSM=IDLE; every output 0, including active_mode, err_flags and drop_count. Reset mid-run returns to IDLE at once; src_start drops the next edge.
- All outputs registered; 1-cycle latency from source inputs to out_* and usb_*.
- States: IDLE, ARM, RUN, ABORT, DRAIN, DONE.
- IDLE: run_start with mode_sel<NUM_MODES -> latch active_mode, clear err_flags and drop_count, go to ARM. mode_sel>=NUM_MODES -> set bad_mode, stay IDLE. mode_sel changes at any other time are ignored.
- ARM: one cycle; asserts src_start[active_mode]; -> RUN.
- RUN: src_start held. src_done[active] -> DRAIN with src_start dropped. run_stop -> ABORT. Watchdog reaching max -> set timeout, go to ABORT. run_stop and src_done in the same cycle -> DRAIN (done wins).
- ABORT: src_start=0; wait for src_done[active] deasserted->asserted, or watchdog expiry; then -> DRAIN.
- DRAIN: wait for data_transmit_done; -> DONE. Data from the owner is still forwarded.
- DONE: run_done=1 for one cycle; -> IDLE. active_mode holds its last value.
- Watchdog clears on entry to RUN and ABORT and on every forwarded word; increments otherwise; saturates.
- Mux: out_dac, out_ctest, out_sc_load and src_config_done follow active_mode whenever busy. In IDLE they follow mode 0 (normal ACQ path) so USB configuration works without a run.
- Data: usb_data_en = src_data_en[active] & ~usb_fifo_full & state in {RUN, ABORT, DRAIN}. A strobe during full sets overflow and increments drop_count, saturating at 0xFFFF. Non-owner strobes are ignored and not counted.

Test Plan:
- Reset, then mode_sel=2 and run_start -> ARM next cycle; src_start=4'b0100 two cycles after start; busy=1; active_mode=2.
- Mode 1 running, src_data_en[1] for 10 words with usb_fifo_full high on words 4-5 -> 8 usb writes; drop_count=2; overflow set.
- src_done[1] rises, then data_transmit_done pulses 5 cycles later -> run_done single pulse 1 cycle after DRAIN exit; busy=0.
- TMO_W=4, no data or done in RUN -> timeout set after 15 cycles, src_start=0; src_done then data_transmit_done -> run_done.
- mode_sel=3 while NUM_MODES=3, run_start -> bad_mode=1, stays IDLE, src_start=0. mode_sel toggled during RUN -> active_mode unchanged.
- run_stop and src_done[0] in the same cycle -> DRAIN (not ABORT). Reset asserted mid-RUN -> all outputs 0 on the next edge.
